clk_control_cfg_arbiter: RTL and testbench

Shares the AXI4-Lite register port of the clk_control block (four 32-bit registers at byte offsets 0x0/0x4/0x8/0xC) between NUM_REQ independent requesters, e.g. the soft-core config path and the TMR fault handler. It accepts simple single-word read/write commands, arbitrates between them, and sequences one AXI4-Lite transaction at a time on a master port. It returns read data and response to the originating requester only. It sits in the block design between the requesters and the clk_control S00_AXI slave.

---
 rtl/clk_control_cfg_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_clk_control_cfg_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_control_cfg_arbiter.sv
// clk_control_cfg_arbiter
// Shares the AXI4-Lite register port of clk_control between NUM_REQ
// requesters. One single-word transaction is in flight at a time and its
// completion is returned only to the requester that issued it.
// Build option: define CLKCTRL_ARB_RR_EN for round-robin arbitration;
// without it the lowest-index requester wins and no pointer is built.

module clk_control_cfg_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,

    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_REQ*4-1:0]           req_wstrb,

    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic [1:0]                     rsp_resp,
    output logic                           busy,

    output logic [ADDR_WIDTH-1:0]          m_axi_awaddr,
    output logic [2:0]                     m_axi_awprot,
    output logic                           m_axi_awvalid,
    input  logic                           m_axi_awready,
    output logic [DATA_WIDTH-1:0]          m_axi_wdata,
    output logic [3:0]                     m_axi_wstrb,
    output logic                           m_axi_wvalid,
    input  logic                           m_axi_wready,
    input  logic [1:0]                     m_axi_bresp,
    input  logic                           m_axi_bvalid,
    output logic                           m_axi_bready,
    output logic [ADDR_WIDTH-1:0]          m_axi_araddr,
    output logic [2:0]                     m_axi_arprot,
    output logic                           m_axi_arvalid,
    input  logic                           m_axi_arready,
    input  logic [DATA_WIDTH-1:0]          m_axi_rdata,
    input  logic [1:0]                     m_axi_rresp,
    input  logic                           m_axi_rvalid,
    output logic                           m_axi_rready
);

    localparam int                    IDX_W      = (NUM_REQ > 2) ? 2 : 1;
    localparam logic [IDX_W:0]        NUM_REQ_W  = (IDX_W + 1)'(NUM_REQ);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH - 2){1'b1}}, 2'b00};

    // state     | meaning
    // ----------+-----------------------------------------------------------
    // S_IDLE    | waiting for a command; grant issued and command latched here
    // S_WR_ADDR | AW and W offered; each dropped on its own handshake
    // S_WR_RESP | waiting for the write response (bready high)
    // S_RD_ADDR | AR offered
    // S_RD_RESP | waiting for read data (rready high)
    // S_DONE    | one-cycle rsp_valid pulse to the originator; no new grant
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ADDR = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_RESP = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic                    bready_q, bready_d;
    logic                    rready_q, rready_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic                    busy_q, busy_d;

    logic                    gnt_found;
    logic [IDX_W-1:0]        gnt_idx;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [3:0]              sel_wstrb;

`ifdef CLKCTRL_ARB_RR_EN
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [NUM_REQ-1:0]      rr_vec;
    logic [IDX_W:0]          rr_sum;
    logic [IDX_W:0]          ptr_nxt;

    // Round-robin: first asserted request at or above the pointer, wrapping.
    always_comb begin
        rr_vec    = NUM_REQ'({req_valid, req_valid} >> ptr_q);
        rr_sum    = '0;
        gnt_found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rr_vec[k]) begin
                gnt_found = 1'b1;
                rr_sum    = {1'b0, ptr_q} + (IDX_W + 1)'(k);
            end
        end
        if (rr_sum >= NUM_REQ_W) begin
            rr_sum = rr_sum - NUM_REQ_W;
        end
        gnt_idx = rr_sum[IDX_W-1:0];
    end

    // Pointer moves to the slot after the granted requester, only on grant.
    always_comb begin
        ptr_d   = ptr_q;
        ptr_nxt = {1'b0, gnt_idx} + (IDX_W + 1)'(1);
        if (ptr_nxt >= NUM_REQ_W) begin
            ptr_nxt = '0;
        end
        if (state_q == S_IDLE && gnt_found) begin
            ptr_d = ptr_nxt[IDX_W-1:0];
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: lowest asserted index wins.
    always_comb begin
        gnt_found = |req_valid;
        gnt_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                gnt_idx = IDX_W'(k);
            end
        end
    end
`endif

    // Select the granted requester's command fields.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_idx == IDX_W'(k)) begin
                sel_we    = req_we[k];
                sel_addr  = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
                sel_wstrb = req_wstrb[k*4 +: 4];
            end
        end
    end

    // Accept is combinational so the command is taken in the grant cycle.
    always_comb begin
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_ready[k] = (state_q == S_IDLE) && gnt_found && (gnt_idx == IDX_W'(k));
        end
    end

    // Next-state and next-output computation for the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        rsp_valid_d = '0;
        rdata_d     = rdata_q;
        resp_d      = resp_q;

        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    gnt_d   = gnt_idx;
                    addr_d  = sel_addr & ALIGN_MASK;
                    wdata_d = sel_wdata;
                    wstrb_d = sel_wstrb;
                    if (sel_we) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR_ADDR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = S_RD_ADDR;
                    end
                end
            end
            S_WR_ADDR: begin
                if (m_axi_awready) begin
                    awvalid_d = 1'b0;
                end
                if (m_axi_wready) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (m_axi_bvalid) begin
                    bready_d = 1'b0;
                    resp_d   = m_axi_bresp;
                    rdata_d  = '0;
                    for (int k = 0; k < NUM_REQ; k++) begin
                        rsp_valid_d[k] = (gnt_q == IDX_W'(k));
                    end
                    state_d  = S_DONE;
                end
            end
            S_RD_ADDR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_RESP;
                end
            end
            S_RD_RESP: begin
                if (m_axi_rvalid) begin
                    rready_d = 1'b0;
                    rdata_d  = m_axi_rdata;
                    resp_d   = m_axi_rresp;
                    for (int k = 0; k < NUM_REQ; k++) begin
                        rsp_valid_d[k] = (gnt_q == IDX_W'(k));
                    end
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset abandons any in-flight transaction.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
            resp_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            busy_q      <= busy_d;
        end
    end

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_clk_control_cfg_arbiter.sv
// Bench for clk_control_cfg_arbiter: a small AXI4-Lite register slave with
// programmable ready delays, per-requester command drivers, a bus monitor
// and a vector table of single-requester commands with expected results.

module tb_clk_control_cfg_arbiter;

    localparam int NR = 2;

    logic            ACLK = 1'b0;
    logic            ARESETN = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   req_we = '0;
    logic [NR*4-1:0] req_addr = '0;
    logic [NR*32-1:0] req_wdata = '0;
    logic [NR*4-1:0] req_wstrb = '0;
    logic [NR-1:0]   rsp_valid;
    logic [31:0]     rsp_rdata;
    logic [1:0]      rsp_resp;
    logic            busy;
    logic [3:0]      m_axi_awaddr;
    logic [2:0]      m_axi_awprot;
    logic            m_axi_awvalid;
    logic            m_axi_awready;
    logic [31:0]     m_axi_wdata;
    logic [3:0]      m_axi_wstrb;
    logic            m_axi_wvalid;
    logic            m_axi_wready;
    logic [1:0]      m_axi_bresp;
    logic            m_axi_bvalid;
    logic            m_axi_bready;
    logic [3:0]      m_axi_araddr;
    logic [2:0]      m_axi_arprot;
    logic            m_axi_arvalid;
    logic            m_axi_arready;
    logic [31:0]     m_axi_rdata;
    logic [1:0]      m_axi_rresp;
    logic            m_axi_rvalid;
    logic            m_axi_rready;

    clk_control_cfg_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    // ---------------- slave model ----------------
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    bit          b_stall = 0, rerr_en = 0;
    int          aw_wait, w_wait, ar_wait;
    logic        aw_done, w_done;
    logic [31:0] mem [4];

    assign m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
    assign m_axi_wready  = m_axi_wvalid  && (w_wait  >= w_delay);
    assign m_axi_arready = m_axi_arvalid && (ar_wait >= ar_delay);

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
            aw_done <= 1'b0; w_done <= 1'b0;
            m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00;
            m_axi_rvalid <= 1'b0; m_axi_rresp <= 2'b00; m_axi_rdata <= '0;
        end else begin
            aw_wait <= (m_axi_awvalid && !m_axi_awready) ? aw_wait + 1 : 0;
            w_wait  <= (m_axi_wvalid  && !m_axi_wready)  ? w_wait + 1  : 0;
            ar_wait <= (m_axi_arvalid && !m_axi_arready) ? ar_wait + 1 : 0;
            if (m_axi_bvalid && m_axi_bready) begin
                m_axi_bvalid <= 1'b0;
            end else if (!m_axi_bvalid && !b_stall &&
                         (aw_done || (m_axi_awvalid && m_axi_awready)) &&
                         (w_done  || (m_axi_wvalid  && m_axi_wready))) begin
                for (int b = 0; b < 4; b++)
                    if (m_axi_wstrb[b]) mem[m_axi_awaddr[3:2]][8*b +: 8] <= m_axi_wdata[8*b +: 8];
                m_axi_bvalid <= 1'b1;
                m_axi_bresp  <= 2'b00;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                aw_done <= aw_done || (m_axi_awvalid && m_axi_awready);
                w_done  <= w_done  || (m_axi_wvalid  && m_axi_wready);
            end
            if (m_axi_rvalid && m_axi_rready) begin
                m_axi_rvalid <= 1'b0;
            end else if (!m_axi_rvalid && m_axi_arvalid && m_axi_arready) begin
                m_axi_rvalid <= 1'b1;
                m_axi_rdata  <= mem[m_axi_araddr[3:2]];
                m_axi_rresp  <= (rerr_en && m_axi_araddr == 4'h8) ? 2'b10 : 2'b00;
            end
        end
    end

    // ---------------- monitor ----------------
    typedef struct {
        int          rid;
        int          lat;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } rsp_t;

    rsp_t rsp_log[$];
    int   gnt_log[$];
    int   last_acc = 0;
    int   rsp_cnt [NR];
    int   awv_cyc = 0, wv_cyc = 0, b_cnt = 0, aw_hs = 0, ar_hs = 0;
    int   payload_bad = 0, stab_bad = 0, onehot_bad = 0;
    bit   prev_aw = 0, prev_w = 0, prev_ar = 0;
    logic [3:0]  prev_awaddr, prev_araddr;
    logic [31:0] prev_wdata;

    initial begin
        rsp_t r;
        for (int i = 0; i < NR; i++) rsp_cnt[i] = 0;
        forever begin
            @(negedge ACLK);
            #2;
            if (ARESETN) begin
                for (int i = 0; i < NR; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        gnt_log.push_back(i);
                        last_acc = cyc;
                    end
                end
                if ($countones(rsp_valid) > 1) onehot_bad++;
                for (int i = 0; i < NR; i++) begin
                    if (rsp_valid[i]) begin
                        rsp_cnt[i]++;
                        r.rid = i; r.lat = cyc - last_acc;
                        r.rdata = rsp_rdata; r.resp = rsp_resp;
                        rsp_log.push_back(r);
                    end
                end
                if (m_axi_awvalid) awv_cyc++;
                if (m_axi_wvalid) wv_cyc++;
                if (m_axi_bvalid && m_axi_bready) b_cnt++;
                if (m_axi_awvalid && m_axi_awready) aw_hs++;
                if (m_axi_arvalid && m_axi_arready) ar_hs++;
                if (m_axi_awvalid && (m_axi_awaddr[1:0] != 2'b00 || m_axi_awprot != 3'b000)) payload_bad++;
                if (m_axi_arvalid && (m_axi_araddr[1:0] != 2'b00 || m_axi_arprot != 3'b000)) payload_bad++;
                if (prev_aw && (!m_axi_awvalid || m_axi_awaddr != prev_awaddr)) stab_bad++;
                if (prev_w  && (!m_axi_wvalid  || m_axi_wdata  != prev_wdata))  stab_bad++;
                if (prev_ar && (!m_axi_arvalid || m_axi_araddr != prev_araddr)) stab_bad++;
                prev_aw = m_axi_awvalid && !m_axi_awready;
                prev_w  = m_axi_wvalid  && !m_axi_wready;
                prev_ar = m_axi_arvalid && !m_axi_arready;
                prev_awaddr = m_axi_awaddr;
                prev_wdata  = m_axi_wdata;
                prev_araddr = m_axi_araddr;
            end else begin
                prev_aw = 0; prev_w = 0; prev_ar = 0;
            end
        end
    end

    // ---------------- checking helpers ----------------
    int tests = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input int i, input bit we, input logic [3:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        bit got = 0;
        @(negedge ACLK);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i*4 +: 4]   = a;
        req_wdata[i*32 +: 32] = d;
        req_wstrb[i*4 +: 4]  = s;
        for (int k = 0; k < 200 && !got; k++) begin
            #1;
            if (req_ready[i]) got = 1;
            else @(negedge ACLK);
        end
        if (got) begin
            @(posedge ACLK);
            #1;
        end
        req_valid[i] = 1'b0;
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL accept_timeout: requester %0d not accepted, expected accept", i);
        end
    endtask

    task automatic wait_rsp(input string name, output rsp_t r, output bit ok);
        ok = 0;
        r.rid = -1; r.lat = -1; r.rdata = '0; r.resp = '0;
        for (int k = 0; k < 100 && !ok; k++) begin
            if (rsp_log.size() > 0) begin
                r = rsp_log.pop_front();
                ok = 1;
            end else begin
                @(negedge ACLK);
                #3;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL %s_rsp_timeout: got no rsp_valid, expected one", name);
        end
    endtask

    task automatic pulse_reset();
        @(negedge ACLK);
        ARESETN = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    typedef struct {
        bit          we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [12];
    rsp_t r;
    bit   ok;
    int   exp_g [12];

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = '0;
        vecs[0]  = '{1'b1, 4'h0, 32'h1, 4'hF, 32'h0, 2'b00};
        vecs[1]  = '{1'b1, 4'h4, 32'h2, 4'hF, 32'h0, 2'b00};
        vecs[2]  = '{1'b1, 4'h8, 32'h3, 4'hF, 32'h0, 2'b00};
        vecs[3]  = '{1'b1, 4'hC, 32'h4, 4'hF, 32'h0, 2'b00};
        vecs[4]  = '{1'b0, 4'h0, 32'h0, 4'h0, 32'h1, 2'b00};
        vecs[5]  = '{1'b0, 4'h4, 32'h0, 4'h0, 32'h2, 2'b00};
        vecs[6]  = '{1'b0, 4'h8, 32'h0, 4'h0, 32'h3, 2'b00};
        vecs[7]  = '{1'b0, 4'hC, 32'h0, 4'h0, 32'h4, 2'b00};
        vecs[8]  = '{1'b1, 4'h0, 32'hFFFF_FFAB, 4'b0001, 32'h0, 2'b00};
        vecs[9]  = '{1'b0, 4'h0, 32'h0, 4'h0, 32'h0000_00AB, 2'b00};
        vecs[10] = '{1'b1, 4'h6, 32'h55, 4'hF, 32'h0, 2'b00};
        vecs[11] = '{1'b0, 4'h5, 32'h0, 4'h0, 32'h55, 2'b00};

        // reset values
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_axi_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 32'h0);
        chk("rst_rsp_data", rsp_rdata | 32'(rsp_resp) | 32'(m_axi_awaddr) | m_axi_wdata, 32'h0);
        @(negedge ACLK);
        ARESETN = 1'b1;

        // vector table, requester 0, zero-wait slave
        for (int v = 0; v < 12; v++) begin
            issue(0, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb);
            wait_rsp($sformatf("vec%0d", v), r, ok);
            if (ok) begin
                chk($sformatf("vec%0d_rid", v), 32'(r.rid), 32'd0);
                chk($sformatf("vec%0d_rdata", v), r.rdata, vecs[v].exp_rdata);
                chk($sformatf("vec%0d_resp", v), 32'(r.resp), 32'(vecs[v].exp_resp));
                chk($sformatf("vec%0d_latency", v), 32'(r.lat), 32'd3);
            end
        end

        // both requesters continuously requesting, 6 reads each
        pulse_reset();
        gnt_log.delete();
        rsp_log.delete();
        fork
            for (int j = 0; j < 6; j++) issue(0, 1'b0, 4'h8, 32'h0, 4'h0);
            for (int j = 0; j < 6; j++) issue(1, 1'b0, 4'hC, 32'h0, 4'h0);
        join
`ifdef CLKCTRL_ARB_RR_EN
        for (int j = 0; j < 12; j++) exp_g[j] = j % 2;
`else
        for (int j = 0; j < 12; j++) exp_g[j] = (j < 6) ? 0 : 1;
`endif
        for (int j = 0; j < 12; j++) begin
            wait_rsp($sformatf("arb%0d", j), r, ok);
            if (ok) begin
                chk($sformatf("arb%0d_rsp_rid", j), 32'(r.rid), 32'(exp_g[j]));
                chk($sformatf("arb%0d_rdata", j), r.rdata, (exp_g[j] == 0) ? 32'h3 : 32'h4);
            end
        end
        chk("arb_grant_count", 32'(gnt_log.size()), 32'd12);
        for (int j = 0; j < 12 && j < gnt_log.size(); j++)
            chk($sformatf("arb_grant%0d", j), 32'(gnt_log[j]), 32'(exp_g[j]));

        // awready delayed, wready immediate
        @(negedge ACLK);
        aw_delay = 2;
        awv_cyc = 0; wv_cyc = 0; b_cnt = 0;
        rsp_cnt[0] = 0; rsp_cnt[1] = 0;
        issue(0, 1'b1, 4'h4, 32'hA5A5_A5A5, 4'hF);
        wait_rsp("awdly", r, ok);
        if (ok) begin
            chk("awdly_rid", 32'(r.rid), 32'd0);
            chk("awdly_latency", 32'(r.lat), 32'd5);
        end
        repeat (4) @(negedge ACLK);
        chk("awdly_awvalid_cycles", 32'(awv_cyc), 32'd3);
        chk("awdly_wvalid_cycles", 32'(wv_cyc), 32'd1);
        chk("awdly_b_count", 32'(b_cnt), 32'd1);
        chk("awdly_rsp_count", 32'(rsp_cnt[0] + rsp_cnt[1]), 32'd1);
        aw_delay = 0;

        // error response on requester 1 read of 0x8
        rerr_en = 1;
        rsp_cnt[0] = 0; rsp_cnt[1] = 0;
        issue(1, 1'b0, 4'h8, 32'h0, 4'h0);
        wait_rsp("rerr", r, ok);
        if (ok) begin
            chk("rerr_rid", 32'(r.rid), 32'd1);
            chk("rerr_resp", 32'(r.resp), 32'h2);
            chk("rerr_rdata", r.rdata, 32'h3);
        end
        repeat (3) @(negedge ACLK);
        chk("rerr_req0_pulses", 32'(rsp_cnt[0]), 32'd0);
        rerr_en = 0;

        // reset in WR_RESP
        b_stall = 1;
        rsp_log.delete();
        issue(0, 1'b1, 4'h0, 32'hDEAD_BEEF, 4'hF);
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge ACLK);
            #1;
            if (m_axi_bready) ok = 1;
        end
        chk("rstmid_reached_wr_resp", 32'(ok), 32'd1);
        ARESETN = 1'b0;
        #1;
        chk("rstmid_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 32'h0);
        chk("rstmid_busy", 32'(busy), 32'h0);
        chk("rstmid_ready_rsp", 32'({req_ready, rsp_valid}), 32'h0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        b_stall = 0;
        issue(0, 1'b0, 4'h4, 32'h0, 4'h0);
        wait_rsp("rstmid_read", r, ok);
        if (ok) begin
            chk("rstmid_read_rid", 32'(r.rid), 32'd0);
            chk("rstmid_read_rdata", r.rdata, 32'hA5A5_A5A5);
            chk("rstmid_read_resp", 32'(r.resp), 32'h0);
            chk("rstmid_read_latency", 32'(r.lat), 32'd3);
        end

        // requester 0 withdraws while requester 1 is served
        ar_delay = 3;
        repeat (2) @(negedge ACLK);
        gnt_log.delete();
        rsp_log.delete();
        ar_hs = 0; aw_hs = 0;
        rsp_cnt[0] = 0; rsp_cnt[1] = 0;
        fork
            issue(1, 1'b0, 4'hC, 32'h0, 4'h0);
            begin
                repeat (2) @(negedge ACLK);
                req_we[0] = 1'b0;
                req_addr[3:0] = 4'h0;
                req_valid[0] = 1'b1;
                repeat (2) @(negedge ACLK);
                req_valid[0] = 1'b0;
            end
        join
        wait_rsp("withdraw", r, ok);
        if (ok) begin
            chk("withdraw_rid", 32'(r.rid), 32'd1);
            chk("withdraw_rdata", r.rdata, 32'h4);
        end
        repeat (6) @(negedge ACLK);
        chk("withdraw_grants", 32'(gnt_log.size()), 32'd1);
        chk("withdraw_ar_count", 32'(ar_hs + aw_hs), 32'd1);
        chk("withdraw_req0_pulses", 32'(rsp_cnt[0]), 32'd0);
        ar_delay = 0;

        // protocol properties over the whole run
        chk("addr_align_prot", 32'(payload_bad), 32'd0);
        chk("payload_stable", 32'(stab_bad), 32'd0);
        chk("rsp_onehot", 32'(onehot_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
